// File: rtl/sap_ram_pkg.sv
// Shared SAP bus-machine constants and the RAM controller state encoding.
// Other bus modules (pc, ir, alu registers) take their default widths from here.
package sap_ram_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } sap_state_t;

endpackage

// File: rtl/sap_ram_sync_edge.sv
// Multi-stage synchroniser for an asynchronous button followed by a rising-edge pulse.
// While preset is high the detector tracks the level silently, so a button held on entry never fires.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic preset,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   level;

  assign level = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= level;
    end
  end

  assign pulse = level & ~prev_reg & ~preset;

endmodule

// File: rtl/sap_ram.sv
// SAP RAM with integrated MAR: post-reset clear sweep, bus-controlled run mode,
// front-panel program mode with optional auto-increment, and a tri-state bus driver.
module sap_ram
  import sap_ram_pkg::*;
#(
  parameter int DATA_W      = SAP_DATA_W,
  parameter int ADDR_W      = SAP_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              mar_load_n,
  input  logic              ram_write_n,
  input  logic              ram_out_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_write,
  input  logic              prog_auto_inc,
  output logic [ADDR_W-1:0] mar_out,
  output logic              ready
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];

  sap_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] mar_reg, mar_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              ready_reg, ready_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] prog_waddr;
  logic              prog_pulse;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_prog_btn (
    .clk   (clk),
    .rst   (rst),
    .din   (prog_write),
    .preset(state_reg != ST_PROG),
    .pulse (prog_pulse)
  );

  assign prog_waddr = prog_auto_inc ? ptr_reg : prog_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
      mar_reg   <= '0;
      ptr_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mar_reg   <= mar_next;
      ptr_reg   <= ptr_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mar_next   = mar_reg;
    ptr_next   = ptr_reg;
    ready_next = ready_reg;
    mem_we     = 1'b0;
    mem_waddr  = mar_reg;
    mem_wdata  = bus_in;
    case (state_reg)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = prog_mode ? ST_PROG : ST_RUN;
          ready_next = 1'b1;
        end
      end
      ST_RUN: begin
        // Write addresses the MAR value from before this edge, even when MAR loads too.
        mem_we = ~ram_write_n;
        if (!mar_load_n) mar_next = bus_in[ADDR_W-1:0];
        if (!prog_auto_inc) ptr_next = prog_addr;
        if (prog_mode) state_next = ST_PROG;
      end
      ST_PROG: begin
        mar_next = prog_waddr;
        if (!prog_auto_inc) ptr_next = prog_addr;
        if (!prog_mode) begin
          state_next = ST_RUN;
        end else if (prog_pulse) begin
          mem_we    = 1'b1;
          mem_waddr = prog_waddr;
          mem_wdata = prog_data;
          if (prog_auto_inc) ptr_next = ptr_reg + 1'b1;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus_out = (!ram_out_n && state_reg != ST_CLEAR) ? mem[mar_reg] : {DATA_W{1'bz}};
  assign mar_out = mar_reg;
  assign ready   = ready_reg;

endmodule

// File: tb/tb_sap_ram.sv
// Randomised scoreboard bench for sap_ram: stimulus queues expectations from a word-level model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sap_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_mode, mar_load_n, ram_write_n, ram_out_n;
  logic [7:0] bus_in;
  wire  [7:0] bus_out;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_write, prog_auto_inc;
  logic [3:0] mar_out;
  logic       ready;

  sap_ram dut (
    .clk          (clk),
    .rst          (rst),
    .prog_mode    (prog_mode),
    .mar_load_n   (mar_load_n),
    .ram_write_n  (ram_write_n),
    .ram_out_n    (ram_out_n),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_write   (prog_write),
    .prog_auto_inc(prog_auto_inc),
    .mar_out      (mar_out),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  // kind: 0 = bus value, 1 = bus high-Z, 2 = mar_out, 3 = ready
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] mem_m [16];
  logic [3:0] mar_m;

  always @(negedge clk) begin : monitor
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      case (it.kind)
        0: if (bus_out !== it.exp) begin
             errors++;
             $display("FAIL %s: bus_out=%h required=%h", it.name, bus_out, it.exp);
           end
        1: if (bus_out !== 8'bzzzz_zzzz) begin
             errors++;
             $display("FAIL %s: bus_out=%h required=zz", it.name, bus_out);
           end
        2: if (mar_out !== it.exp[3:0]) begin
             errors++;
             $display("FAIL %s: mar_out=%h required=%h", it.name, mar_out, it.exp[3:0]);
           end
        default: if (ready !== it.exp[0]) begin
             errors++;
             $display("FAIL %s: ready=%b required=%b", it.name, ready, it.exp[0]);
           end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int kind, input logic [7:0] exp);
    sb_item_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    mar_m = 4'h0;
  endtask

  // One RUN-mode bus cycle; expectations describe the outputs before this op's edge.
  task automatic run_op(input bit ld, input bit wr, input bit oe, input logic [7:0] d);
    mar_load_n  = ~ld;
    ram_write_n = ~wr;
    ram_out_n   = ~oe;
    bus_in      = d;
    if (oe) push("run_read", 0, mem_m[mar_m]);
    else    push("run_z", 1, 8'h00);
    push("run_mar", 2, {4'h0, mar_m});
    $display("run ld=%0d wr=%0d oe=%0d bus_in=%h mar=%h", ld, wr, oe, d, mar_m);
    tick();
    if (wr) mem_m[mar_m] = d;
    if (ld) mar_m = d[3:0];
    mar_load_n  = 1'b1;
    ram_write_n = 1'b1;
    ram_out_n   = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      run_op(1'b1, 1'b0, 1'b0, 8'(a));
      run_op(1'b0, 1'b0, 1'b1, 8'($urandom));
    end
  endtask

  // Starts right after reset release; bus controls are held active to show they are ignored.
  task automatic sweep_check();
    for (int i = 0; i < 18; i++) begin
      ram_out_n   = 1'b0;
      mar_load_n  = (i >= 16);
      ram_write_n = (i >= 16);
      bus_in      = 8'($urandom);
      push("sweep_ready", 3, {7'h0, (i >= 16)});
      if (i < 16) push("sweep_z", 1, 8'h00);
      else        push("sweep_read", 0, mem_m[mar_m]);
      $display("sweep cycle=%0d", i);
      tick();
    end
    ram_out_n   = 1'b1;
    mar_load_n  = 1'b1;
    ram_write_n = 1'b1;
  endtask

  task automatic press(input logic [7:0] d, input int hold, input int gap);
    prog_data  = d;
    prog_write = 1'b1;
    $display("press data=%h addr=%h auto=%0d", d, prog_addr, prog_auto_inc);
    repeat (hold) tick();
    prog_write = 1'b0;
    repeat (gap) tick();
  endtask

  logic [7:0] inc_data [3];

  initial begin
    rst = 1'b1; prog_mode = 1'b0; prog_write = 1'b0; prog_auto_inc = 1'b0;
    prog_addr = 4'h0; prog_data = 8'h00; bus_in = 8'h00;
    mar_load_n = 1'b1; ram_write_n = 1'b1; ram_out_n = 1'b0;
    inc_data[0] = 8'h11; inc_data[1] = 8'h22; inc_data[2] = 8'h33;

    tick();
    push("rst_ready", 3, 8'h00);
    push("rst_mar", 2, 8'h00);
    push("rst_z", 1, 8'h00);
    tick();
    rst = 1'b0;
    model_reset();
    sweep_check();

    // Fill with FF, then prove a reset mid-sweep restarts the clear in full
    for (int a = 0; a < 16; a++) begin
      run_op(1'b1, 1'b0, 1'b0, 8'(a));
      run_op(1'b0, 1'b1, 1'b0, 8'hFF);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    push("midrst_ready", 3, 8'h00);
    tick();
    rst = 1'b0;
    model_reset();
    sweep_check();
    read_all();

    // Directed run write/read and same-edge load+write
    run_op(1'b1, 1'b0, 1'b0, 8'h0A);
    run_op(1'b0, 1'b1, 1'b0, 8'h5C);
    run_op(1'b0, 1'b0, 1'b1, 8'h00);
    run_op(1'b1, 1'b0, 1'b0, 8'h03);
    run_op(1'b1, 1'b1, 1'b0, 8'h07);
    run_op(1'b0, 1'b0, 1'b1, 8'h00);
    run_op(1'b1, 1'b0, 1'b0, 8'h03);
    run_op(1'b0, 1'b0, 1'b1, 8'h00);

    // Random bus traffic with tri-state toggling
    for (int n = 0; n < 80; n++)
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    read_all();

    // Program mode, no auto-increment: held button writes once
    prog_addr = 4'h2; prog_data = 8'h9E; prog_mode = 1'b1;
    tick(); tick();
    push("prog_mar", 2, 8'h02);
    prog_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) prog_data = 8'h55;
      tick();
    end
    mem_m[2] = 8'h9E;
    $display("press data=9e addr=2 held 10 cycles");
    prog_write = 1'b0; prog_data = 8'h66;
    repeat (6) tick();
    prog_mode = 1'b0;
    tick(); tick();
    mar_m = 4'h2;
    read_all();

    // Auto-increment with wrap from F to 0
    prog_addr = 4'hE; prog_mode = 1'b1;
    tick(); tick();
    prog_auto_inc = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      press(inc_data[k], 4, 4);
      mem_m[4'(14 + k)] = inc_data[k];
    end
    push("autoinc_ptr", 2, 8'h01);
    tick();
    prog_mode = 1'b0; prog_auto_inc = 1'b0;
    tick(); tick();
    mar_m = 4'hE;
    read_all();

    // Entering PROG with the button already held must not write
    prog_addr = 4'h5; prog_data = 8'hAB; prog_write = 1'b1;
    repeat (4) tick();
    prog_mode = 1'b1;
    repeat (6) tick();
    push("held_entry_mar", 2, 8'h05);
    tick();
    prog_mode = 1'b0; prog_write = 1'b0;
    tick(); tick();
    mar_m = 4'h5;
    read_all();

    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
